// File: rtl/regfile_pkg.sv
// Shared constants and types for the RV32 integer register file.
// Optional macro: REGFILE_BYPASS_EN (write-to-read forwarding in the read ports).
package regfile_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xlen_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: register mux, x0 forced to zero,
// optional same-cycle forwarding of the pending write (REGFILE_BYPASS_EN).
module regfile_rd_port #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic [(2**AW)-1:0][XLEN-1:0] regs,
    input  logic [AW-1:0]                rs_addr,
    input  logic [AW-1:0]                rd_addr,
    input  logic                         reg_we,
    input  logic [XLEN-1:0]              rd_wdata,
    output logic [XLEN-1:0]              rs_data
);
    import regfile_pkg::*;

    logic rs_is_zero;

    assign rs_is_zero = (rs_addr == AW'(ZERO_REG));

`ifdef REGFILE_BYPASS_EN
    logic bypass_hit;

    assign bypass_hit = reg_we && !rs_is_zero && (rs_addr == rd_addr);

    // Select stored value, pending write data on a hit, zero for x0
    always_comb begin
        rs_data = regs[rs_addr];
        if (bypass_hit) begin
            rs_data = rd_wdata;
        end
        if (rs_is_zero) begin
            rs_data = '0;
        end
    end
`else
    logic unused_bypass;

    assign unused_bypass = ^{rd_addr, reg_we, rd_wdata};

    // Select stored value, zero for x0
    always_comb begin
        rs_data = regs[rs_addr];
        if (rs_is_zero) begin
            rs_data = '0;
        end
    end
`endif

endmodule

// File: rtl/reg_file.sv
// RV32 integer register file: flop array, one write port, two read ports.
// Optional macro: REGFILE_BYPASS_EN (forward rd_wdata to matching reads).
module reg_file #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] rd_wdata,
    input  logic [AW-1:0]   rd_addr,
    input  logic            reg_we,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data
);
    import regfile_pkg::*;

    localparam int NREGS = 2**AW;

    logic [NREGS-1:0][XLEN-1:0] regs_q;
    logic [NREGS-1:0][XLEN-1:0] regs_d;

    logic wr_en;

    assign wr_en = reg_we && (rd_addr != AW'(ZERO_REG));

    // Next-state: update the addressed register, x0 pinned to zero
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[rd_addr] = rd_wdata;
        end
        regs_d[0] = '0;
    end

    // Register array with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_rd_port #(
        .XLEN (XLEN),
        .AW   (AW)
    ) u_rs1_port (
        .regs     (regs_q),
        .rs_addr  (rs1_addr),
        .rd_addr  (rd_addr),
        .reg_we   (reg_we),
        .rd_wdata (rd_wdata),
        .rs_data  (rs1_data)
    );

    regfile_rd_port #(
        .XLEN (XLEN),
        .AW   (AW)
    ) u_rs2_port (
        .regs     (regs_q),
        .rs_addr  (rs2_addr),
        .rd_addr  (rd_addr),
        .reg_we   (reg_we),
        .rd_wdata (rd_wdata),
        .rs_data  (rs2_data)
    );

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
// Expected values follow REGFILE_BYPASS_EN when it is defined.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic [31:0] rd_wdata;
    logic [4:0]  rd_addr;
    logic        reg_we;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    int errors = 0;
    int checks = 0;

    reg_file #(
        .XLEN (32),
        .AW   (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_wdata (rd_wdata),
        .rd_addr  (rd_addr),
        .reg_we   (reg_we),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic we, input logic [4:0] a,
                      input logic [31:0] d);
        @(negedge clk);
        reg_we   = we;
        rd_addr  = a;
        rd_wdata = d;
        @(posedge clk);
        #1;
        reg_we   = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        rs1_addr = a1;
        rs2_addr = a2;
        #1;
    endtask

    logic [31:0] byp_exp;

    initial begin
        rst      = 1'b1;
        reg_we   = 1'b0;
        rd_addr  = '0;
        rd_wdata = '0;
        rs1_addr = '0;
        rs2_addr = '0;

        // reset held for two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rd(5'd0, 5'd1);
        chk("rst_x0", rs1_data, 32'h0);
        chk("rst_x1", rs2_data, 32'h0);
        rd(5'd2, 5'd3);
        chk("rst_x2", rs1_data, 32'h0);
        chk("rst_x3", rs2_data, 32'h0);

        // basic write
        wr(1'b1, 5'd5, 32'hAAAA_AAAA);
        rd(5'd5, 5'd0);
        chk("wr_x5", rs1_data, 32'hAAAA_AAAA);
        chk("wr_x5_rs2_x0", rs2_data, 32'h0);

        // x0 write discarded
        wr(1'b1, 5'd10, 32'hBBBB_BBBB);
        wr(1'b1, 5'd0, 32'h1111_1111);
        rd(5'd0, 5'd10);
        chk("x0_discard", rs1_data, 32'h0);
        chk("wr_x10", rs2_data, 32'hBBBB_BBBB);
        rd(5'd0, 5'd0);
        chk("x0_both_p1", rs1_data, 32'h0);
        chk("x0_both_p2", rs2_data, 32'h0);

        // write enable low
        wr(1'b0, 5'd7, 32'h1234_5678);
        rd(5'd7, 5'd7);
        chk("we0_x7", rs1_data, 32'h0);

        // same register on both ports
        wr(1'b1, 5'd31, 32'hFFFF_FFFF);
        rd(5'd31, 5'd31);
        chk("x31_p1", rs1_data, 32'hFFFF_FFFF);
        chk("x31_p2", rs2_data, 32'hFFFF_FFFF);

        // fill x1..x31 with distinct patterns
        for (int i = 1; i < 32; i++) begin
            wr(1'b1, 5'(i), 32'h0101_0101 * i + 32'h8000_0000);
        end
        for (int i = 1; i < 32; i++) begin
            rd(5'(i), 5'(32 - i));
            chk("fill_p1", rs1_data, 32'h0101_0101 * i + 32'h8000_0000);
            chk("fill_p2", rs2_data,
                32'h0101_0101 * (32 - i) + 32'h8000_0000);
        end

        // asynchronous reset mid-cycle, no edge needed
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(i));
            chk("async_rst_p1", rs1_data, 32'h0);
            chk("async_rst_p2", rs2_data, 32'h0);
        end

        // edge with reset high does not write
        wr(1'b1, 5'd4, 32'hDEAD_BEEF);
        rd(5'd4, 5'd4);
        chk("rst_blocks_wr", rs1_data, 32'h0);

        // bypass window: write pending, read before the edge
        @(negedge clk);
        rst      = 1'b0;
        reg_we   = 1'b1;
        rd_addr  = 5'd3;
        rd_wdata = 32'hCAFE_F00D;
        rd(5'd3, 5'd3);
`ifdef REGFILE_BYPASS_EN
        byp_exp = 32'hCAFE_F00D;
`else
        byp_exp = 32'h0;
`endif
        chk("pre_edge_p1", rs1_data, byp_exp);
        chk("pre_edge_p2", rs2_data, byp_exp);
        @(posedge clk);
        #1;
        chk("post_edge_p1", rs1_data, 32'hCAFE_F00D);
        chk("post_edge_p2", rs2_data, 32'hCAFE_F00D);

        // x0 never forwarded
        @(negedge clk);
        reg_we   = 1'b1;
        rd_addr  = 5'd0;
        rd_wdata = 32'h5555_5555;
        rd(5'd0, 5'd3);
        chk("x0_no_bypass", rs1_data, 32'h0);
        chk("x3_held", rs2_data, 32'hCAFE_F00D);
        @(posedge clk);
        #1;
        reg_we = 1'b0;
        chk("x0_after", rs1_data, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

RV32 integer register file for the single-cycle core: 32 × 32-bit architectural registers x0–x31 with two combinational read ports (rs1, rs2) and one synchronous write port (rd). It sits between the decoder, which supplies the register addresses, and the ALU/writeback path, which consumes read data and drives write data. x0 is hardwired to zero.

## Interface
- `XLEN`, default 32: data width of every register and data port.
- `AW`, default 5: register address width; register count is 2**AW.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high; clears every register.
- `rd_wdata`  in  XLEN  write data.
- `rd_addr`  in  AW  write address.
- `reg_we`  in  1  write enable, sampled at the rising edge of `clk`.
- `rs1_addr`  in  AW  read port 1 address.
- `rs2_addr`  in  AW  read port 2 address.
- `rs1_data`  out  XLEN  register[rs1_addr], combinational.
- `rs2_data`  out  XLEN  register[rs2_addr], combinational.

## Operation
- Write: at the rising edge of `clk`, with `rst` low and `reg_we`=1, register[`rd_addr`] ← `rd_wdata`.
- Writes to x0 are discarded. x0 always reads 0, whatever the write history.
- With `reg_we`=0, no register changes.
- Reads are purely combinational from the addresses. No read enable. Reads never alter state.
- Both ports may address the same register, including x0. They then return identical data.
- No X propagation: after reset every register reads a defined value.

## Timing
- `rst` high: all registers 0 immediately, with no clock edge required. Outputs follow combinationally, so `rs1_data`/`rs2_data` read 0 during reset.
- While `rst` is high, writes are ignored. Deassertion takes effect from the next rising edge, and a write may occur on that edge.
- `rst` asserted mid-operation: all contents are lost. An edge coinciding with `rst` high does not write.
- Write latency: data written at edge N is visible on the read ports after edge N, in the same cycle and combinationally.
- Read of `rd_addr` while a write to it is pending in the same cycle: behaviour is set by the bypass option in Configuration.

## Configuration
- `REGFILE_BYPASS_EN` defined: write-to-read forwarding is enabled. If `reg_we`=1, `rd_addr`≠0 and `rsN_addr`==`rd_addr`, then `rsN_data`=`rd_wdata` combinationally, before the edge. x0 is never bypassed.
- `REGFILE_BYPASS_EN` undefined: reads return the stored value. The new value appears only after the edge.

## Structure
- Package `regfile_pkg` holds:
  - `XLEN`=32, `REG_AW`=5, `NUM_REGS`=32
  - `ZERO_REG`=5'd0
  - typedef `reg_addr_t` (logic [REG_AW-1:0])
  - typedef `xlen_t` (logic [XLEN-1:0])
- Sub-module `regfile_rd_port`, instantiated twice (rs1, rs2), performs:
  - 32:1 read mux
  - x0 forcing to zero
  - optional bypass compare against `rd_addr`/`reg_we`/`rd_wdata`
- Storage array and write logic live in the top `reg_file`. Use registers only, with no memory macro, for async-reset support.

## Test plan
- Hold reset for 2 cycles, release -> (x0,x1) and (x2,x3) all read 0x00000000.
- Write x5=0xAAAAAAAA -> after the edge, rs1=x5 reads 0xAAAAAAAA and rs2=x0 reads 0.
- Write x10=0xBBBBBBBB, then write x0=0x11111111 -> rs1=x0 reads 0 and rs2=x10 reads 0xBBBBBBBB.
- Write x7=0x12345678 with `reg_we`=0 -> x7 stays 0. Write x31=0xFFFFFFFF, then read x31 on both ports -> both 0xFFFFFFFF.
- Fill x1..x31, then assert `rst` mid-cycle -> every read returns 0 before the next edge.
- Present a write to x3=0xCAFEF00D and read x3 before the edge -> 0xCAFEF00D with `REGFILE_BYPASS_EN`, 0 without. Both settings read 0xCAFEF00D after the edge.
